// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator for the VGA output path. It produces
// hsync, vsync and data-enable with programmable geometry and polarity. It
// also produces a pixel request stream that runs LEAD ticks ahead of the
// display, so a frame-buffer read with latency can be issued early.
//
// Two raster positions are tracked with two counter pairs:
//   F (fetch)   -> req, req_x, req_y
//   D (display) -> hsync, vsync, de, x, y, line_start, frame_start, frame_cnt
// D always trails F by LEAD ticks (modulo one frame).
//
// Ports:
//   pclk        in   pixel clock
//   reset_n     in   synchronous, active-low reset (wins over clk_en)
//   clk_en      in   tick qualifier; the raster advances only when it is 1
//   hsync       out  horizontal sync, HSYNC_POL while in the sync region
//   vsync       out  vertical sync, VSYNC_POL while in the sync lines
//   de          out  display position is inside the active area
//   x, y        out  display column/line, 0 when de=0
//   line_start  out  one-pclk pulse when display position is (0,y), y<V_ACTIVE
//   frame_start out  one-pclk pulse when display position is (0,0)
//   req         out  fetch position is inside the active area
//   req_x/req_y out  fetch column/line, 0 when req=0
//   frame_cnt   out  completed-frame count, wraps at 2^FRAME_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int LEAD      = 2,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               clk_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic               req,
    output logic [CNT_W-1:0]   req_x,
    output logic [CNT_W-1:0]   req_y,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // D starts LEAD positions before (0,0). Since LEAD <= H_BP < HT this is
    // always on the last line, inside its back porch.
    localparam logic [CNT_W-1:0] D_INIT_H = (LEAD == 0) ? '0 : CNT_W'(HT - LEAD);
    localparam logic [CNT_W-1:0] D_INIT_V = (LEAD == 0) ? '0 : V_LAST;

    localparam logic HS_ON  = 1'(HSYNC_POL);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = 1'(VSYNC_POL);
    localparam logic VS_OFF = ~VS_ON;

    function automatic logic [CNT_W-1:0] next_h(input logic [CNT_W-1:0] h);
        return (h == H_LAST) ? '0 : h + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] next_v(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] v);
        if (h != H_LAST)
            return v;
        return (v == V_LAST) ? '0 : v + CNT_W'(1);
    endfunction

    function automatic logic in_active(input logic [CNT_W-1:0] h,
                                       input logic [CNT_W-1:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    function automatic logic in_hsync(input logic [CNT_W-1:0] h);
        return (h >= HS_BEG) && (h < HS_END);
    endfunction

    function automatic logic in_vsync(input logic [CNT_W-1:0] v);
        return (v >= VS_BEG) && (v < VS_END);
    endfunction

    // Stage p0: counters hold the positions to be presented on the next tick.
    logic [CNT_W-1:0] f_h_p0;
    logic [CNT_W-1:0] f_v_p0;
    logic [CNT_W-1:0] d_h_p0;
    logic [CNT_W-1:0] d_v_p0;
    // Set at the first frame_start after reset; that one has no completed
    // frame behind it and must not advance frame_cnt.
    logic             frame_seen;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            f_h_p0      <= '0;
            f_v_p0      <= '0;
            d_h_p0      <= D_INIT_H;
            d_v_p0      <= D_INIT_V;
            frame_seen  <= 1'b0;
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            req         <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Pulses are single pclk even when ticks are sparse.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk_en) begin
                f_h_p0 <= next_h(f_h_p0);
                f_v_p0 <= next_v(f_h_p0, f_v_p0);
                d_h_p0 <= next_h(d_h_p0);
                d_v_p0 <= next_v(d_h_p0, d_v_p0);

                // Stage p1: registered decode of the positions presented now.
                req   <= in_active(f_h_p0, f_v_p0);
                req_x <= in_active(f_h_p0, f_v_p0) ? f_h_p0 : '0;
                req_y <= in_active(f_h_p0, f_v_p0) ? f_v_p0 : '0;

                hsync <= in_hsync(d_h_p0) ? HS_ON : HS_OFF;
                vsync <= in_vsync(d_v_p0) ? VS_ON : VS_OFF;
                de    <= in_active(d_h_p0, d_v_p0);
                x     <= in_active(d_h_p0, d_v_p0) ? d_h_p0 : '0;
                y     <= in_active(d_h_p0, d_v_p0) ? d_v_p0 : '0;

                line_start <= (d_h_p0 == '0) && (d_v_p0 < V_ACT);
                if ((d_h_p0 == '0) && (d_v_p0 == '0)) begin
                    frame_start <= 1'b1;
                    frame_seen  <= 1'b1;
                    if (frame_seen)
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule
